// File: rtl/gpio_pkg.sv
// Shared defaults and sizing helper for the GPIO switch debouncer.
// Counter width is derived here so every instance sizes identically.
package gpio_pkg;

  localparam int GPIO_WIDTH_DEF    = 4;
  localparam int GPIO_DEBOUNCE_DEF = 100000;

  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch channel: 2-flop synchronizer, hold counter, stable level and edge pulses.
// Latency 2 + DEBOUNCE_CYCLES from raw sample to stable update; no backpressure.
module switch_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_settled
);

  localparam int             CW      = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync_q;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync_q <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync_q <= r_sync1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      // Any return to the stable level throws away the partial count.
      if (r_sync_q == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_stable <= r_sync_q;
        r_cnt    <= '0;
        r_rise   <= r_sync_q;
        r_fall   <= ~r_sync_q;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_settled = (r_sync_q == r_stable);

endmodule

// File: rtl/gpio_switch_debounce.sv
// WIDTH independent debounced switch channels with rise/fall pulses and a settled flag.
// Latency 2 + DEBOUNCE_CYCLES per channel; no backpressure.
module gpio_switch_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF
) (
  input  logic             SYSTEMCLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] gpio_switch_raw,
  output logic [WIDTH-1:0] gpio_switch,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             switch_changed,
  output logic             settled
);

  logic [WIDTH-1:0] w_settled;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk    (SYSTEMCLOCK),
      .i_rst_n  (RESET_N),
      .i_raw    (gpio_switch_raw[g]),
      .o_stable (gpio_switch[g]),
      .o_rise   (switch_rise[g]),
      .o_fall   (switch_fall[g]),
      .o_settled(w_settled[g])
    );
  end

  assign switch_changed = |{switch_rise, switch_fall};
  assign settled        = &w_settled;

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Self-checking bench for gpio_switch_debounce with DEBOUNCE_CYCLES = 16.
module tb_gpio_switch_debounce;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw;
  logic [W-1:0] gpio_switch;
  logic [W-1:0] switch_rise;
  logic [W-1:0] switch_fall;
  logic         switch_changed;
  logic         settled;

  always #5 clk = ~clk;

  gpio_switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .SYSTEMCLOCK    (clk),
    .RESET_N        (rst_n),
    .gpio_switch_raw(raw),
    .gpio_switch    (gpio_switch),
    .switch_rise    (switch_rise),
    .switch_fall    (switch_fall),
    .switch_changed (switch_changed),
    .settled        (settled)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model works in the raw-sample domain and schedules its result
  // two edges later, where the DUT's synchronizer delay makes it visible.
  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_lvl;
  int           m_run[W];
  bit           armed = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      repeat (3) sb.push_back('0);
      m_lvl = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      armed = 1'b1;
    end else if (armed) begin
      e = '0;
      for (int i = 0; i < W; i++) begin
        if (raw[i] !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            m_lvl[i] = raw[i];
            m_run[i] = 0;
            e.r[i]   = raw[i];
            e.f[i]   = ~raw[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      e.g = m_lvl;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_gpio", 32'(gpio_switch), 32'(e.g));
      check("sb_rise", 32'(switch_rise), 32'(e.r));
      check("sb_fall", 32'(switch_fall), 32'(e.f));
      check("sb_changed", 32'(switch_changed), 32'(|{e.r, e.f}));
    end
  end

  task automatic wait_gpio(input logic [W-1:0] target, output int lat);
    lat = 0;
    while (gpio_switch !== target && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt_a;
    int cnt_b;
    rst_n = 1'b0;
    raw   = '0;
    repeat (3) @(negedge clk);
    check("rst_settled", 32'(settled), 32'd1);
    check("rst_gpio", 32'(gpio_switch), 32'd0);
    rst_n = 1'b1;

    // Quiet inputs: nothing happens, always settled.
    cnt_a = 0;
    repeat (50) begin
      @(negedge clk);
      if (settled !== 1'b1) cnt_a++;
    end
    check("idle_unsettled_cycles", 32'(cnt_a), 32'd0);
    check("idle_gpio", 32'(gpio_switch), 32'd0);

    // Single rising edge on channel 0.
    raw = 4'h1;
    wait_gpio(4'h1, lat);
    check("rise_latency", 32'(lat), 32'd18);
    check("rise_pulse", 32'(switch_rise), 32'h1);
    check("rise_changed", 32'(switch_changed), 32'd1);
    @(negedge clk);
    check("rise_pulse_one_cycle", 32'(switch_rise), 32'h0);

    // Bouncing channel 0 never holds long enough.
    cnt_a = 0;
    cnt_b = 0;
    lat   = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) raw[0] = ~raw[0];
      @(negedge clk);
      if (settled) cnt_a++; else cnt_b++;
      if (switch_changed) lat++;
    end
    check("bounce_settled_high_seen", 32'(cnt_a > 0), 32'd1);
    check("bounce_settled_low_seen", 32'(cnt_b > 0), 32'd1);
    check("bounce_pulses", 32'(lat), 32'd0);
    check("bounce_gpio", 32'(gpio_switch), 32'h1);

    // Multi-channel fall: F -> A.
    raw = 4'hF;
    repeat (30) @(negedge clk);
    check("all_high_gpio", 32'(gpio_switch), 32'hF);
    raw = 4'hA;
    wait_gpio(4'hA, lat);
    check("fall_latency", 32'(lat), 32'd18);
    check("fall_pulse", 32'(switch_fall), 32'h5);
    check("fall_no_rise", 32'(switch_rise), 32'h0);

    // Channel 2 held one cycle short of acceptance.
    raw[2] = 1'b1;
    repeat (15) @(negedge clk);
    raw[2] = 1'b0;
    lat = 0;
    repeat (30) begin
      @(negedge clk);
      if (switch_changed) lat++;
    end
    check("short_hold_pulses", 32'(lat), 32'd0);
    check("short_hold_gpio", 32'(gpio_switch), 32'hA);
    check("short_hold_settled", 32'(settled), 32'd1);

    // Reset in the middle of a count.
    raw = 4'h0;
    repeat (30) @(negedge clk);
    check("clear_gpio", 32'(gpio_switch), 32'h0);
    raw = 4'h8;
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (switch_changed) lat++;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (switch_changed) lat++;
    end
    check("midreset_pulses", 32'(lat), 32'd0);
    check("midreset_settled", 32'(settled), 32'd1);
    check("midreset_gpio", 32'(gpio_switch), 32'h0);
    rst_n = 1'b1;
    wait_gpio(4'h8, lat);
    check("post_reset_latency", 32'(lat), 32'd18);
    check("post_reset_rise", 32'(switch_rise), 32'h8);

    // Random hold lengths around the threshold, scoreboard-checked.
    for (int s = 0; s < 40; s++) begin
      raw = W'($urandom);
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end
    repeat (25) @(negedge clk);
    check("final_gpio", 32'(gpio_switch), 32'(raw));
    check("final_settled", 32'(settled), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
